// File: rtl/triplet_loader_if.sv
// Sample-in / triplet-out bus of triplet_loader: upstream handshake, flush,
// triplet presentation with acknowledge, comparator result and counters.
interface triplet_loader_if #(
   parameter int unsigned DATA_W = 3,
   parameter int unsigned CNT_W  = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              flush;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] c;
   logic              trip_valid;
   logic              trip_ready;
   logic              cmp_in;
   logic [CNT_W-1:0]  trip_count;
   logic [CNT_W-1:0]  match_count;

   // Stimulus / consumer side
   modport master (
      output in_valid, in_data, flush, trip_ready, cmp_in,
      input  in_ready, a, b, c, trip_valid, trip_count, match_count
   );

   // Loader side
   modport slave (
      input  in_valid, in_data, flush, trip_ready, cmp_in,
      output in_ready, a, b, c, trip_valid, trip_count, match_count
   );
endinterface

// File: rtl/triplet_loader.sv
// Assembles a stream of samples into an (a, b, c) triplet for the triple comparator
// and counts acknowledged triplets and matches. Optional macro: SLIDE_WINDOW_EN.
module triplet_loader #(
   parameter int unsigned DATA_W = 3,
   parameter int unsigned CNT_W  = 8
) (
   input logic              clk,
   input logic              rst_n,
   triplet_loader_if.slave  bus
);

   localparam logic [2:0] ST_LOAD_A  = 3'd0;
   localparam logic [2:0] ST_LOAD_B  = 3'd1;
   localparam logic [2:0] ST_LOAD_C  = 3'd2;
   localparam logic [2:0] ST_PRESENT = 3'd3;
`ifdef SLIDE_WINDOW_EN
   localparam logic [2:0] ST_SLIDE   = 3'd4;
   localparam logic [2:0] ST_AFTER_ACK = ST_SLIDE;
`else
   localparam logic [2:0] ST_AFTER_ACK = ST_LOAD_A;
`endif

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;

   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_c;
   logic [DATA_W-1:0] w_a_nxt;
   logic [DATA_W-1:0] w_b_nxt;
   logic [DATA_W-1:0] w_c_nxt;

   logic              r_trip_valid;
   logic              w_trip_valid_nxt;
   logic              r_in_ready;
   logic              w_in_ready_nxt;

   logic [CNT_W-1:0]  r_trip_count;
   logic [CNT_W-1:0]  r_match_count;
   logic [CNT_W-1:0]  w_trip_count_nxt;
   logic [CNT_W-1:0]  w_match_count_nxt;

   logic              w_accept;
   logic              w_ack;

   // flush masks both handshakes so a sample or ack in the flush cycle is dropped
   assign w_accept = bus.in_valid & r_in_ready & ~bus.flush;
   assign w_ack    = r_trip_valid & bus.trip_ready & ~bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_LOAD_A;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output logic; every registered output is computed here
   always_comb begin
      w_state_nxt       = r_state;
      w_a_nxt           = r_a;
      w_b_nxt           = r_b;
      w_c_nxt           = r_c;
      w_trip_valid_nxt  = r_trip_valid;
      w_trip_count_nxt  = r_trip_count;
      w_match_count_nxt = r_match_count;

      if (bus.flush) begin
         w_state_nxt      = ST_LOAD_A;
         w_a_nxt          = '0;
         w_b_nxt          = '0;
         w_c_nxt          = '0;
         w_trip_valid_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_LOAD_A: begin
               if (w_accept) begin
                  w_a_nxt     = bus.in_data;
                  w_state_nxt = ST_LOAD_B;
               end
            end
            ST_LOAD_B: begin
               if (w_accept) begin
                  w_b_nxt     = bus.in_data;
                  w_state_nxt = ST_LOAD_C;
               end
            end
            ST_LOAD_C: begin
               if (w_accept) begin
                  w_c_nxt          = bus.in_data;
                  w_trip_valid_nxt = 1'b1;
                  w_state_nxt      = ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (w_ack) begin
                  w_trip_count_nxt  = r_trip_count + CNT_W'(1);
                  w_match_count_nxt = r_match_count + CNT_W'(bus.cmp_in);
                  w_trip_valid_nxt  = 1'b0;
                  w_state_nxt       = ST_AFTER_ACK;
               end
            end
`ifdef SLIDE_WINDOW_EN
            ST_SLIDE: begin
               if (w_accept) begin
                  w_a_nxt          = r_b;
                  w_b_nxt          = r_c;
                  w_c_nxt          = bus.in_data;
                  w_trip_valid_nxt = 1'b1;
                  w_state_nxt      = ST_PRESENT;
               end
            end
`endif
            default: begin
               w_state_nxt      = ST_LOAD_A;
               w_trip_valid_nxt = 1'b0;
            end
         endcase
      end

      // Ready in every loading state, low only while a triplet is presented
      w_in_ready_nxt = (w_state_nxt != ST_PRESENT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a           <= '0;
         r_b           <= '0;
         r_c           <= '0;
         r_trip_valid  <= 1'b0;
         r_in_ready    <= 1'b0;
         r_trip_count  <= '0;
         r_match_count <= '0;
      end else begin
         r_a           <= w_a_nxt;
         r_b           <= w_b_nxt;
         r_c           <= w_c_nxt;
         r_trip_valid  <= w_trip_valid_nxt;
         r_in_ready    <= w_in_ready_nxt;
         r_trip_count  <= w_trip_count_nxt;
         r_match_count <= w_match_count_nxt;
      end
   end

   assign bus.a           = r_a;
   assign bus.b           = r_b;
   assign bus.c           = r_c;
   assign bus.trip_valid  = r_trip_valid;
   assign bus.in_ready    = r_in_ready;
   assign bus.trip_count  = r_trip_count;
   assign bus.match_count = r_match_count;

endmodule

// File: tb/tb_triplet_loader.sv
// Directed bench for triplet_loader: an 8-bit-counter instance plus a 2-bit-counter
// instance sharing the same stimulus, checked against hand-computed values.
module tb_triplet_loader;

   logic clk = 1'b0;
   logic rst_n;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0] r_seen [$];

   triplet_loader_if #(.DATA_W(3), .CNT_W(8)) u_if  ();
   triplet_loader_if #(.DATA_W(3), .CNT_W(2)) u_if2 ();

   assign u_if2.in_valid   = u_if.in_valid;
   assign u_if2.in_data    = u_if.in_data;
   assign u_if2.flush      = u_if.flush;
   assign u_if2.trip_ready = u_if.trip_ready;
   assign u_if2.cmp_in     = u_if.cmp_in;

   triplet_loader #(.DATA_W(3), .CNT_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   triplet_loader #(.DATA_W(3), .CNT_W(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge
   task automatic step(input bit mon);
      @(posedge clk);
      #1;
      if (mon && u_if.trip_valid)
         r_seen.push_back({u_if.a, u_if.b, u_if.c});
   endtask

   // Offer one sample after `gap` idle cycles, waiting (bounded) for in_ready
   task automatic put(input logic [2:0] d, input int gap, input bit mon);
      int budget;
      repeat (gap) step(mon);
      u_if.in_valid = 1'b1;
      u_if.in_data  = d;
      budget = 0;
      while (!u_if.in_ready && budget < 20) begin
         step(mon);
         budget++;
      end
      if (budget >= 20) chk("put_timeout", 32'd0, 32'd1);
      step(mon);
      u_if.in_valid = 1'b0;
   endtask

   task automatic ack(input logic cmp);
      u_if.cmp_in     = cmp;
      u_if.trip_ready = 1'b1;
      step(1'b0);
      u_if.trip_ready = 1'b0;
      u_if.cmp_in     = 1'b0;
   endtask

   task automatic do_flush();
      u_if.flush = 1'b1;
      step(1'b0);
      u_if.flush = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1'b0);
      step(1'b0);
      rst_n = 1'b1;
      step(1'b0);
   endtask

   initial begin
      rst_n           = 1'b0;
      u_if.in_valid   = 1'b0;
      u_if.in_data    = '0;
      u_if.flush      = 1'b0;
      u_if.trip_ready = 1'b0;
      u_if.cmp_in     = 1'b0;

      // Reset state and release
      #2;
      chk("rst_in_ready", 32'(u_if.in_ready), 32'd0);
      chk("rst_trip_valid", 32'(u_if.trip_valid), 32'd0);
      step(1'b0);
      rst_n = 1'b1;
      chk("release_in_ready_pre", 32'(u_if.in_ready), 32'd0);
      step(1'b0);
      chk("release_in_ready", 32'(u_if.in_ready), 32'd1);

      // Reset in the middle of a triplet
      put(3'd3, 0, 1'b0);
      chk("midb_a", 32'(u_if.a), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("midb_rst_a", 32'(u_if.a), 32'd0);
      chk("midb_rst_in_ready", 32'(u_if.in_ready), 32'd0);
      step(1'b0);
      rst_n = 1'b1;
      step(1'b0);
      chk("midb_rel_in_ready", 32'(u_if.in_ready), 32'd1);

      // Back-to-back 3,4,1 held for 10 cycles, then acknowledged with a match
      put(3'd3, 0, 1'b0);
      put(3'd4, 0, 1'b0);
      put(3'd1, 0, 1'b0);
      chk("t2_valid", 32'(u_if.trip_valid), 32'd1);
      chk("t2_in_ready", 32'(u_if.in_ready), 32'd0);
      u_if.in_valid = 1'b1;
      u_if.in_data  = 3'd7;
      repeat (10) step(1'b0);
      u_if.in_valid = 1'b0;
      chk("t2_held", 32'({u_if.a, u_if.b, u_if.c, u_if.trip_valid}), 32'({3'd3, 3'd4, 3'd1, 1'b1}));
      ack(1'b1);
      chk("t2_trip_count", 32'(u_if.trip_count), 32'd1);
      chk("t2_match_count", 32'(u_if.match_count), 32'd1);
      chk("t2_in_ready", 32'(u_if.in_ready), 32'd1);
      chk("t2_valid_low", 32'(u_if.trip_valid), 32'd0);
      do_flush();

      // Samples with idle gaps
      put(3'd2, 0, 1'b0);
      put(3'd5, 2, 1'b0);
      chk("t3_not_yet", 32'(u_if.trip_valid), 32'd0);
      put(3'd6, 3, 1'b0);
      chk("t3_trip", 32'({u_if.a, u_if.b, u_if.c, u_if.trip_valid}), 32'({3'd2, 3'd5, 3'd6, 1'b1}));
      ack(1'b0);
      chk("t3_counts", 32'({u_if.trip_count, u_if.match_count}), 32'({8'd2, 8'd1}));
      do_flush();

      // Flush together with a sample drops it and clears the partial triplet
      put(3'd3, 0, 1'b0);
      put(3'd4, 0, 1'b0);
      u_if.in_valid = 1'b1;
      u_if.in_data  = 3'd7;
      do_flush();
      u_if.in_valid = 1'b0;
      chk("t4_cleared", 32'({u_if.a, u_if.b, u_if.c, u_if.trip_valid, u_if.in_ready}),
          32'({3'd0, 3'd0, 3'd0, 1'b0, 1'b1}));
      put(3'd1, 0, 1'b0);
      put(3'd2, 0, 1'b0);
      put(3'd3, 0, 1'b0);
      chk("t4_trip", 32'({u_if.a, u_if.b, u_if.c, u_if.trip_valid}), 32'({3'd1, 3'd2, 3'd3, 1'b1}));
      // Flush beats an ack offered in the same cycle
      u_if.trip_ready = 1'b1;
      u_if.cmp_in     = 1'b1;
      do_flush();
      u_if.trip_ready = 1'b0;
      u_if.cmp_in     = 1'b0;
      chk("t4_flush_ack_valid", 32'(u_if.trip_valid), 32'd0);
      chk("t4_counts", 32'({u_if.trip_count, u_if.match_count}), 32'({8'd2, 8'd1}));
      // Stray trip_ready while nothing presented
      ack(1'b1);
      chk("t4_stray_ready", 32'(u_if.trip_count), 32'd2);

      // Counter wrap with a 2-bit counter
      do_reset();
      chk("t5_rst_count", 32'(u_if2.trip_count), 32'd0);
      for (int k = 0; k < 5; k++) begin
         logic [2:0] kv;
         kv = 3'(k);
         put(kv, 0, 1'b0);
         put(kv, 0, 1'b0);
         put(kv, 0, 1'b0);
         ack((k == 1) ? 1'b0 : 1'b1);
         do_flush();
      end
      chk("t5_wrap_trip", 32'(u_if2.trip_count), 32'd1);
      chk("t5_wrap_match", 32'(u_if2.match_count), 32'd0);
      chk("t5_wide_counts", 32'({u_if.trip_count, u_if.match_count}), 32'({8'd5, 8'd4}));

      // Continuous stream with the consumer always ready
      do_reset();
      r_seen.delete();
      u_if.trip_ready = 1'b1;
      for (int k = 1; k <= 5; k++) put(3'(k), 0, 1'b1);
      repeat (4) step(1'b1);
      u_if.trip_ready = 1'b0;
`ifdef SLIDE_WINDOW_EN
      chk("t6_num", 32'(r_seen.size()), 32'd3);
      if (r_seen.size() == 3) begin
         chk("t6_trip0", 32'(r_seen[0]), 32'({3'd1, 3'd2, 3'd3}));
         chk("t6_trip1", 32'(r_seen[1]), 32'({3'd2, 3'd3, 3'd4}));
         chk("t6_trip2", 32'(r_seen[2]), 32'({3'd3, 3'd4, 3'd5}));
      end
      chk("t6_trip_count", 32'(u_if.trip_count), 32'd3);
`else
      chk("t6_num", 32'(r_seen.size()), 32'd1);
      if (r_seen.size() == 1)
         chk("t6_trip0", 32'(r_seen[0]), 32'({3'd1, 3'd2, 3'd3}));
      chk("t6_trip_count", 32'(u_if.trip_count), 32'd1);
      chk("t6_partial_ab", 32'({u_if.a, u_if.b, u_if.trip_valid}), 32'({3'd4, 3'd5, 1'b0}));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
